tx_odelay_ctrl: RTL
===================

# tx_odelay_ctrl

Runtime ODELAY controller for the TX_BITSLICE lanes of the native-mode HSSIO transmit path. It is the transmit-side counterpart of the RX IDELAY controller. Commands arrive from a 16-bit slice of the AXI control register. The block handles the EN_VTC handshake with BITSLICE_CONTROL, then reads, steps or loads the TX delay tap value. Result and status go to a 16-bit slice of the AXI status register.

## Interface
Parameters:
- STEP_MAX, 8: largest tap change applied per LOAD pulse (1..15).
- VTC_WAIT, 10: riu_clk cycles held after EN_VTC falls and before EN_VTC rises.
- SETTLE, 5: riu_clk cycles waited after each LOAD pulse before re-reading cntvalue_out.

Ports:
- riu_clk, input, 1: block clock. Reset riu_rst is asynchronous and active-high. Clock is riu_clk.
- riu_rst, input, 1: asynchronous active-high reset.
- ctrl_reg_16b, input, 16: [15] trigger (rising edge starts a command); [14:12] cmd; [8:0] value.
- cntvalue_out, input, 9: current TX tap value from the bitslice.
- bsc_dly_rdy, input, 1: BITSLICE_CONTROL.DLY_RDY.
- bsc_vtc_rdy, input, 1: BITSLICE_CONTROL.VTC_RDY.
- status_reg_16b, output, 16: {done, busy, err, 4'b0, read_delay[8:0]}.
- cntvalue_in, output, 9: tap value presented with load.
- load, output, 1: one-cycle LOAD strobe.
- ce, output, 1: one-cycle CE strobe.
- inc, output, 1: direction qualifier for ce (1 = increment).
- tx_en_vtc, output, 1: TX_BITSLICE.EN_VTC.

## Operation
- Trigger: ctrl_reg_16b[15] is registered. A rising edge means the previous sample was 0 and the current sample is 1.
  - In IDLE, the edge latches cmd and value, sets busy=1, and clears done and err.
  - While busy=1, edges are ignored and not queued.
- Commands:
  - 0 READ: no tap change.
  - 1 INC: apply value[3:0] increment steps.
  - 2 DEC: apply value[3:0] decrement steps.
  - 3 LOAD: converge on the absolute target value[8:0].
  - 4..7: set err=1 and make no tap change; the full VTC sequence still runs.
- States: IDLE -> WAIT_RDY -> VTC_LOW -> WAIT_PRE -> DECODE -> {STEP_PULSE/STEP_GAP | CALC/LOAD_HI/SETTLE} -> WAIT_POST -> VTC_HIGH -> IDLE.
- WAIT_RDY: hold until bsc_dly_rdy=1 and bsc_vtc_rdy=1.
- VTC_LOW: drive tx_en_vtc=0.
- WAIT_PRE: VTC_VAIT cycles.
- DECODE: capture read_delay=cntvalue_out, then branch on cmd.
- INC/DEC, per step:
  - STEP_PULSE asserts ce=1 for one cycle, with inc=1 for INC and inc=0 for DEC.
  - STEP_GAP holds ce=0 for one cycle.
  - Before each pulse, if cntvalue_out=511 (INC) or 0 (DEC), stop stepping and set err=1 (saturation).
  - N=0 produces no pulses.
- LOAD, per iteration:
  - CALC: diff=|value−cntvalue_out| (9-bit unsigned, computed with the larger operand first); step=min(diff, STEP_MAX).
  - If diff=0, exit to WAIT_POST.
  - Otherwise cntvalue_in=cntvalue_out±step. The result is never outside 0..511 by construction.
  - LOAD_HI: load=1 for one cycle, with cntvalue_in held stable.
  - SETTLE: SETTLE cycles, then return to CALC.
  - Hang guard: if cntvalue_out after SETTLE equals the pre-load value while step≠0, set err=1 and exit to WAIT_POST.
- WAIT_POST: read_delay tracks cntvalue_out every cycle for VTC_WAIT cycles.
- VTC_HIGH: tx_en_vtc=1, done=1, busy=0, return to IDLE.
- done and err hold until the next accepted trigger.

## Timing
- Reset values:
  - load=0, ce=0, inc=0, cntvalue_in=0, tx_en_vtc=1.
  - status_reg_16b=16'h0000.
  - Trigger history register=0, so a trigger already high at reset release does not fire.
- Reset asserted mid-operation: every output returns to its reset value immediately. This includes tx_en_vtc=1, even in the middle of the sequence.
- Trigger edge sampled at cycle T; busy=1 at T+1.
- With the ready signals high, tx_en_vtc falls at T+2.
- First ce or load at T+3+VTC_WAIT+1 or later.
- INC/DEC of N steps: 2N cycles of pulse/gap. ce pulses never occur on consecutive cycles.
- LOAD iteration: 1 (CALC) + 1 (LOAD_HI) + SETTLE cycles.
- tx_en_vtc=0 is continuous from VTC_LOW through WAIT_POST. ce and load are only ever asserted while tx_en_vtc=0.
- ce and load are never asserted in the same cycle.
- READ, total trigger-to-done: 2 + VTC_WAIT + 1 + VTC_WAIT + 1 ≈ 24 cycles at the defaults.

## Test plan
- READ: cntvalue_out=9'd100, ctrl=16'h8000 -> no ce/load pulses; done=1 and status=16'h8064 within 30 cycles; tx_en_vtc low for ≥20 cycles.
- INC saturation: cntvalue_out model starts at 509, ctrl={1,3'd1,3'b0,9'd5} -> exactly 2 ce pulses with inc=1; final 511; err=1.
- LOAD large: 200 -> target 150 -> load values 192, 184, …, 152, then 150 (7 loads); each load is followed by 5 idle cycles; done with read_delay=150.
- Hang guard: bitslice model ignores load, target 300 from 100 -> exactly one load; err=1; done=1; tx_en_vtc returns to 1.
- Handshake and busy: hold bsc_vtc_rdy=0 for 50 cycles after the trigger -> tx_en_vtc stays 1 and no pulses occur; a second trigger edge during busy is ignored (exactly one command executes).
- Reset mid-LOAD: assert riu_rst during SETTLE -> tx_en_vtc=1, load=0, status=0 immediately; after release, no activity until a new trigger edge.

Source files
------------

// File: rtl/tx_odelay_ctrl.sv
// tx_odelay_ctrl: runtime ODELAY controller for the TX_BITSLICE lanes.
//
// A rising edge on ctrl_reg_16b[15] starts one command. The controller waits
// for BITSLICE_CONTROL to be ready, drops EN_VTC, then reads the tap, steps it
// (INC/DEC), or converges it on an absolute target (LOAD). It then restores
// EN_VTC and reports the result on status_reg_16b.
//
// Ports:
//   riu_clk        - block clock
//   riu_rst        - asynchronous, active-high reset
//   ctrl_reg_16b   - [15] trigger, [14:12] cmd, [8:0] value
//   cntvalue_out   - current TX tap value from the bitslice
//   bsc_dly_rdy    - BITSLICE_CONTROL.DLY_RDY
//   bsc_vtc_rdy    - BITSLICE_CONTROL.VTC_RDY
//   status_reg_16b - {done, busy, err, 4'b0, read_delay[8:0]}
//   cntvalue_in    - tap value presented with load
//   load           - one-cycle LOAD strobe
//   ce             - one-cycle CE strobe
//   inc            - CE direction (1 = increment)
//   tx_en_vtc      - TX_BITSLICE.EN_VTC
module tx_odelay_ctrl #(
    parameter int unsigned STEP_MAX = 8,
    parameter int unsigned VTC_WAIT = 10,
    parameter int unsigned SETTLE   = 5
) (
    input  logic        riu_clk,
    input  logic        riu_rst,
    input  logic [15:0] ctrl_reg_16b,
    input  logic [8:0]  cntvalue_out,
    input  logic        bsc_dly_rdy,
    input  logic        bsc_vtc_rdy,
    output logic [15:0] status_reg_16b,
    output logic [8:0]  cntvalue_in,
    output logic        load,
    output logic        ce,
    output logic        inc,
    output logic        tx_en_vtc
);

    localparam int unsigned CntW = 16;
    localparam logic [CntW-1:0] VtcWaitM1 = CntW'(VTC_WAIT - 1);
    localparam logic [CntW-1:0] SettleM1  = CntW'(SETTLE - 1);
    localparam logic [8:0]      StepMax   = 9'(STEP_MAX);

    localparam logic [2:0] CmdRead = 3'd0;
    localparam logic [2:0] CmdInc  = 3'd1;
    localparam logic [2:0] CmdDec  = 3'd2;
    localparam logic [2:0] CmdLoad = 3'd3;

    typedef enum logic [3:0] {
        StIdle, StWaitRdy, StVtcLow, StWaitPre, StDecode, StStepPulse, StStepGap,
        StCalc, StLoadHi, StSettle, StWaitPost, StVtcHigh
    } state_e;

    state_e          state_q, state_d;
    logic            trig_q, trig_vld_q;
    logic [2:0]      cmd_q, cmd_d;
    logic [8:0]      value_q, value_d;
    logic [3:0]      steps_q, steps_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [8:0]      pre_q, pre_d;
    logic [8:0]      cntvalue_in_q, cntvalue_in_d;
    logic            load_q, load_d, ce_q, ce_d, inc_q, inc_d, tx_en_vtc_q, tx_en_vtc_d;
    logic            done_q, done_d, busy_q, busy_d, err_q, err_d;
    logic [8:0]      read_delay_q, read_delay_d;

    logic       trig_edge, sat, tgt_ge, to_post;
    logic [8:0] diff, step;

    logic unused_ctrl;
    assign unused_ctrl = ^ctrl_reg_16b[11:9];

    // trig_vld_q masks the first sample after reset so a trigger that is
    // already high at release is not mistaken for an edge.
    assign trig_edge = trig_vld_q & ctrl_reg_16b[15] & ~trig_q;

    // Saturation in the direction of the current step command.
    assign sat = (cmd_q == CmdInc) ? (cntvalue_out == 9'h1FF) : (cntvalue_out == 9'h000);

    assign tgt_ge = (value_q >= cntvalue_out);
    assign diff   = tgt_ge ? (value_q - cntvalue_out) : (cntvalue_out - value_q);
    assign step   = (diff > StepMax) ? StepMax : diff;

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        value_d       = value_q;
        steps_d       = steps_q;
        cnt_d         = cnt_q;
        pre_d         = pre_q;
        cntvalue_in_d = cntvalue_in_q;
        done_d        = done_q;
        busy_d        = busy_q;
        err_d         = err_q;
        read_delay_d  = read_delay_q;
        to_post       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (trig_edge) begin
                    cmd_d   = ctrl_reg_16b[14:12];
                    value_d = ctrl_reg_16b[8:0];
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = StWaitRdy;
                end
            end
            StWaitRdy: begin
                if (bsc_dly_rdy && bsc_vtc_rdy) state_d = StVtcLow;
            end
            StVtcLow: begin
                cnt_d   = VtcWaitM1;
                state_d = StWaitPre;
            end
            StWaitPre: begin
                if (cnt_q == '0) state_d = StDecode;
                else             cnt_d   = cnt_q - 1'b1;
            end
            StDecode: begin
                read_delay_d = cntvalue_out;
                steps_d      = value_q[3:0];
                if (cmd_q == CmdRead) begin
                    to_post = 1'b1;
                end else if (cmd_q == CmdInc || cmd_q == CmdDec) begin
                    if (value_q[3:0] == 4'd0) begin
                        to_post = 1'b1;
                    end else if (sat) begin
                        err_d   = 1'b1;
                        to_post = 1'b1;
                    end else begin
                        state_d = StStepPulse;
                    end
                end else if (cmd_q == CmdLoad) begin
                    state_d = StCalc;
                end else begin
                    err_d   = 1'b1;
                    to_post = 1'b1;
                end
            end
            StStepPulse: begin
                steps_d = steps_q - 4'd1;
                state_d = StStepGap;
            end
            StStepGap: begin
                if (steps_q == 4'd0) begin
                    to_post = 1'b1;
                end else if (sat) begin
                    err_d   = 1'b1;
                    to_post = 1'b1;
                end else begin
                    state_d = StStepPulse;
                end
            end
            StCalc: begin
                if (diff == 9'd0) begin
                    to_post = 1'b1;
                end else begin
                    // step <= diff, so the result stays inside 0..511.
                    pre_d         = cntvalue_out;
                    cntvalue_in_d = tgt_ge ? (cntvalue_out + step) : (cntvalue_out - step);
                    state_d       = StLoadHi;
                end
            end
            StLoadHi: begin
                cnt_d   = SettleM1;
                state_d = StSettle;
            end
            StSettle: begin
                if (cnt_q == '0) begin
                    // Tap did not move after a non-zero load: give up.
                    if (cntvalue_out == pre_q) begin
                        err_d   = 1'b1;
                        to_post = 1'b1;
                    end else begin
                        state_d = StCalc;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StWaitPost: begin
                read_delay_d = cntvalue_out;
                if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StVtcHigh;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StVtcHigh: state_d = StIdle;
            default:   state_d = StIdle;
        endcase

        if (to_post) begin
            cnt_d   = VtcWaitM1;
            state_d = StWaitPost;
        end

        // Strobes are registered from the next state so they align with it.
        ce_d        = (state_d == StStepPulse);
        inc_d       = ce_d && (cmd_q == CmdInc);
        load_d      = (state_d == StLoadHi);
        tx_en_vtc_d = !(state_d inside {StVtcLow, StWaitPre, StDecode, StStepPulse, StStepGap,
                                        StCalc, StLoadHi, StSettle, StWaitPost});
    end

    always_ff @(posedge riu_clk or posedge riu_rst) begin
        if (riu_rst) begin
            state_q       <= StIdle;
            trig_q        <= 1'b0;
            trig_vld_q    <= 1'b0;
            cmd_q         <= 3'd0;
            value_q       <= 9'd0;
            steps_q       <= 4'd0;
            cnt_q         <= '0;
            pre_q         <= 9'd0;
            cntvalue_in_q <= 9'd0;
            load_q        <= 1'b0;
            ce_q          <= 1'b0;
            inc_q         <= 1'b0;
            tx_en_vtc_q   <= 1'b1;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            read_delay_q  <= 9'd0;
        end else begin
            state_q       <= state_d;
            trig_q        <= ctrl_reg_16b[15];
            trig_vld_q    <= 1'b1;
            cmd_q         <= cmd_d;
            value_q       <= value_d;
            steps_q       <= steps_d;
            cnt_q         <= cnt_d;
            pre_q         <= pre_d;
            cntvalue_in_q <= cntvalue_in_d;
            load_q        <= load_d;
            ce_q          <= ce_d;
            inc_q         <= inc_d;
            tx_en_vtc_q   <= tx_en_vtc_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
            read_delay_q  <= read_delay_d;
        end
    end

    assign status_reg_16b = {done_q, busy_q, err_q, 4'b0000, read_delay_q};
    assign cntvalue_in    = cntvalue_in_q;
    assign load           = load_q;
    assign ce             = ce_q;
    assign inc            = inc_q;
    assign tx_en_vtc      = tx_en_vtc_q;

endmodule
